// File: rtl/tc_fetch_sequencer.sv
// tc_fetch_sequencer: PC owner and fetch front end with 1-entry skid buffer and jump squash
module tc_fetch_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int STEP = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_out0,
  input  logic [7:0]            mem_out1,
  input  logic [7:0]            mem_out2,
  input  logic [7:0]            mem_out3,
  input  logic                  jump_valid,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  halt,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready
);
  localparam logic [ADDR_WIDTH-1:0] W_STEP = ADDR_WIDTH'(STEP);
  logic [ADDR_WIDTH-1:0] r_pc, r_pending_pc, r_skid_pc;
  logic                  r_pending, r_skid_valid;
  logic [31:0]           r_skid_instr;
  logic [31:0]           w_word;
  logic                  w_issue;
  assign w_word = {mem_out3, mem_out2, mem_out1, mem_out0};
  always_comb begin
    instr_valid = !rst && (r_skid_valid || r_pending);
    instr       = rst ? '0 : r_skid_valid ? r_skid_instr : r_pending ? w_word : '0;
    instr_pc    = rst ? '0 : r_skid_valid ? r_skid_pc : r_pending ? r_pending_pc : '0;
    mem_addr    = rst ? RESET_PC : jump_valid ? jump_target : r_pc;
    w_issue     = !halt && (instr_ready || !instr_valid);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_pending    <= 1'b0;
      r_pending_pc <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else if (jump_valid) begin
      r_skid_valid <= 1'b0;
      r_pending    <= !halt;
      r_pending_pc <= jump_target;
      r_pc         <= halt ? jump_target : jump_target + W_STEP;
    end else begin
      r_pc      <= w_issue ? r_pc + W_STEP : r_pc;
      r_pending <= w_issue;
      if (w_issue) r_pending_pc <= r_pc;
      if (r_pending && !instr_ready) begin
        r_skid_valid <= 1'b1;
        r_skid_instr <= w_word;
        r_skid_pc    <= r_pending_pc;
      end else if (instr_ready) begin
        r_skid_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tc_fetch_sequencer.sv
// tb_tc_fetch_sequencer: directed checks of fetch sequencing, stall, jump, halt, wrap and reset
module tb_tc_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_addr, mem_addr_w;
  logic [7:0]  m0, m1, m2, m3, w0, w1, w2, w3;
  logic        jump_valid = 1'b0;
  logic [15:0] jump_target = '0;
  logic        halt = 1'b0;
  logic [31:0] instr, instr_w;
  logic [15:0] instr_pc, instr_pc_w;
  logic        instr_valid, instr_valid_w;
  logic        instr_ready = 1'b1;
  int          n_chk = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  tc_fetch_sequencer dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr),
    .mem_out0(m0), .mem_out1(m1), .mem_out2(m2), .mem_out3(m3),
    .jump_valid(jump_valid), .jump_target(jump_target), .halt(halt),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );
  tc_fetch_sequencer #(.RESET_PC(16'hFFF8)) dut_w (
    .clk(clk), .rst(rst), .mem_addr(mem_addr_w),
    .mem_out0(w0), .mem_out1(w1), .mem_out2(w2), .mem_out3(w3),
    .jump_valid(1'b0), .jump_target(16'h0000), .halt(1'b0),
    .instr(instr_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w), .instr_ready(1'b1)
  );
  always @(posedge clk) begin
    m0 <= mem_addr[7:0];
    m1 <= mem_addr[7:0] + 8'd1;
    m2 <= mem_addr[7:0] + 8'd2;
    m3 <= mem_addr[7:0] + 8'd3;
    w0 <= mem_addr_w[7:0];
    w1 <= mem_addr_w[7:0] + 8'd1;
    w2 <= mem_addr_w[7:0] + 8'd2;
    w3 <= mem_addr_w[7:0] + 8'd3;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic nx;
    @(posedge clk);
    #1;
  endtask
  task automatic look(input string tag, input logic v, input logic [15:0] pc, input logic [31:0] ins, input logic [15:0] a);
    chk({tag, " valid"}, 32'(instr_valid), 32'(v));
    chk({tag, " pc"}, 32'(instr_pc), 32'(pc));
    chk({tag, " instr"}, instr, ins);
    chk({tag, " addr"}, 32'(mem_addr), 32'(a));
  endtask
  initial begin
    #4;
    look("reset", 1'b0, 16'h0000, 32'h0, 16'h0000);
    chk("reset wrap valid", 32'(instr_valid_w), 32'h0);
    chk("reset wrap addr", 32'(mem_addr_w), 32'hFFF8);
    nx(); rst = 1'b0; #4;                                    // cycle A
    look("A", 1'b0, 16'h0000, 32'h0, 16'h0000);
    chk("A wrap valid", 32'(instr_valid_w), 32'h0);
    nx(); #4;                                                // B
    look("B", 1'b1, 16'h0000, 32'h03020100, 16'h0004);
    chk("B wrap pc", 32'(instr_pc_w), 32'hFFF8);
    nx(); #4;                                                // C
    look("C", 1'b1, 16'h0004, 32'h07060504, 16'h0008);
    chk("C wrap pc", 32'(instr_pc_w), 32'hFFFC);
    chk("C wrap instr", instr_w, 32'hFFFEFDFC);
    nx(); instr_ready = 1'b0; #4;                            // D: stall 1
    look("D stall", 1'b1, 16'h0008, 32'h0B0A0908, 16'h000C);
    chk("D wrap pc", 32'(instr_pc_w), 32'h0000);
    chk("D wrap instr", instr_w, 32'h03020100);
    nx(); #4;                                                // E: stall 2
    look("E stall", 1'b1, 16'h0008, 32'h0B0A0908, 16'h000C);
    chk("E wrap pc", 32'(instr_pc_w), 32'h0004);
    nx(); #4;                                                // F: stall 3
    look("F stall", 1'b1, 16'h0008, 32'h0B0A0908, 16'h000C);
    nx(); instr_ready = 1'b1; #4;                            // G: release
    look("G release", 1'b1, 16'h0008, 32'h0B0A0908, 16'h000C);
    nx(); #4;                                                // H
    look("H", 1'b1, 16'h000C, 32'h0F0E0D0C, 16'h0010);
    nx(); jump_valid = 1'b1; jump_target = 16'h0100; #4;     // I: jump while 0x10 accepted
    look("I jump", 1'b1, 16'h0010, 32'h13121110, 16'h0100);
    nx(); jump_valid = 1'b0; #4;                             // J
    look("J target", 1'b1, 16'h0100, 32'h03020100, 16'h0104);
    nx(); instr_ready = 1'b0; #4;                            // K: stall fills skid
    look("K", 1'b1, 16'h0104, 32'h07060504, 16'h0108);
    nx(); jump_valid = 1'b1; jump_target = 16'h0233; #4;     // L: jump with skid full
    look("L jump stall", 1'b1, 16'h0104, 32'h07060504, 16'h0233);
    nx(); jump_valid = 1'b0; instr_ready = 1'b1; #4;         // M
    look("M flushed", 1'b1, 16'h0233, 32'h36353433, 16'h0237);
    nx(); halt = 1'b1; #4;                                   // N: halt, pending delivered
    look("N halt", 1'b1, 16'h0237, 32'h3A393837, 16'h023B);
    nx(); #4;                                                // O
    look("O halted", 1'b0, 16'h0000, 32'h0, 16'h023B);
    nx(); #4;                                                // P
    look("P halted", 1'b0, 16'h0000, 32'h0, 16'h023B);
    nx(); halt = 1'b0; #4;                                   // Q: resume
    look("Q resume", 1'b0, 16'h0000, 32'h0, 16'h023B);
    nx(); instr_ready = 1'b0; #4;                            // R
    look("R", 1'b1, 16'h023B, 32'h3E3D3C3B, 16'h023F);
    nx(); #4;                                                // S: skid holds 0x23B
    look("S stall", 1'b1, 16'h023B, 32'h3E3D3C3B, 16'h023F);
    rst = 1'b1; #1;
    look("S rst", 1'b0, 16'h0000, 32'h0, 16'h0000);
    nx(); rst = 1'b0; instr_ready = 1'b1; #4;                // T
    look("T restart", 1'b0, 16'h0000, 32'h0, 16'h0000);
    nx(); #4;                                                // U
    look("U restart", 1'b1, 16'h0000, 32'h03020100, 16'h0004);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
